// File: rtl/pe_array_ctrl_if.sv
// Valid/ready byte stream used for both the load path into the controller
// and the result path out of it.
interface pe_array_ctrl_if #(
    parameter int DW = 8
);
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;
    logic          last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pe_array_ctrl.sv
// Sequencer for a 3x3-filter / 5x5-ifmap PE array: loads operands from a byte
// stream, clears and runs the array, captures its sums and streams them out.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; array held in reset
// S_LOAD    | accepting 9 filter bytes then 25 ifmap bytes
// S_CLR     | one-cycle array reset before the run
// S_RUN     | array enabled for RUN_CYCLES cycles
// S_CAPTURE | array idle; sums latched into the result register on exit
// S_DRAIN   | streaming the 9 result bytes, last marker on the ninth
module pe_array_ctrl #(
    parameter int RUN_CYCLES = 12,
    parameter int DW         = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic                 abort_i,
    pe_array_ctrl_if.slave       ld,
    pe_array_ctrl_if.master      rs,
    input  logic [9*DW-1:0]      sum_in_i,
    output logic [9*DW-1:0]      filter_flat_o,
    output logic [25*DW-1:0]     ifmap_flat_o,
    output logic                 arr_rst_o,
    output logic                 arr_en_o,
    output logic                 busy_o,
    output logic                 done_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CLR, S_RUN, S_CAPTURE, S_DRAIN
    } state_t;

    localparam logic [7:0] RUN_CNT   = 8'(RUN_CYCLES);
    localparam logic [5:0] LAST_BYTE = 6'd33;

    state_t          state_q, state_d;
    logic [5:0]      k_q, k_d;
    logic [3:0]      j_q, j_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            done_q, done_d;
    logic [9*DW-1:0] filter_q;
    logic [25*DW-1:0] ifmap_q;
    logic [9*DW-1:0] result_q;
    logic [5:0]      ifm_idx;
    logic            ld_hs, rs_hs, wr_filt, wr_ifm, cap;

    assign ld_hs   = (state_q == S_LOAD) && ld.valid;
    assign rs_hs   = (state_q == S_DRAIN) && rs.ready;
    assign ifm_idx = k_q - 6'd9;
    // Operand and result writes are suppressed on an abort cycle as well.
    assign wr_filt = ld_hs && !abort_i && (k_q < 6'd9);
    assign wr_ifm  = ld_hs && !abort_i && (k_q >= 6'd9);
    assign cap     = (state_q == S_CAPTURE) && !abort_i;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        j_d     = j_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LOAD;
                    k_d     = '0;
                end
            end
            S_LOAD: begin
                if (ld_hs) begin
                    if (k_q == LAST_BYTE) begin
                        state_d = S_CLR;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + 6'd1;
                    end
                end
            end
            S_CLR: begin
                state_d = S_RUN;
                cnt_d   = RUN_CNT;
            end
            S_RUN: begin
                if (cnt_q == 8'd1) begin
                    state_d = S_CAPTURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            S_CAPTURE: begin
                state_d = S_DRAIN;
                j_d     = '0;
            end
            S_DRAIN: begin
                if (rs_hs) begin
                    if (j_q == 4'd8) begin
                        state_d = S_IDLE;
                        j_d     = '0;
                        done_d  = 1'b1;
                    end else begin
                        j_d = j_q + 4'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_i) begin
            state_d = S_IDLE;
            k_d     = '0;
            j_d     = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            j_q     <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            j_q     <= j_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filter_q <= '0;
            ifmap_q  <= '0;
            result_q <= '0;
        end else begin
            if (wr_filt) filter_q[k_q*DW +: DW]    <= ld.data;
            if (wr_ifm)  ifmap_q[ifm_idx*DW +: DW] <= ld.data;
            if (cap)     result_q                  <= sum_in_i;
        end
    end

    assign ld.ready      = (state_q == S_LOAD);
    assign rs.valid      = (state_q == S_DRAIN);
    assign rs.last       = (state_q == S_DRAIN) && (j_q == 4'd8);
    assign rs.data       = (state_q == S_DRAIN) ? result_q[j_q*DW +: DW] : '0;
    assign busy_o        = (state_q != S_IDLE);
    assign arr_en_o      = (state_q == S_RUN);
    assign arr_rst_o     = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_CLR);
    assign done_o        = done_q;
    assign filter_flat_o = filter_q;
    assign ifmap_flat_o  = ifmap_q;
endmodule

// File: tb/tb_pe_array_ctrl.sv
// Randomized self-checking bench for pe_array_ctrl against a byte-level job model.
`timescale 1ns/1ps
module tb_pe_array_ctrl;
    localparam int RC = 12;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         start  = 1'b0;
    logic         abort  = 1'b0;
    logic [71:0]  sum_in = '0;
    logic [71:0]  filter_flat;
    logic [199:0] ifmap_flat;
    logic         arr_rst, arr_en, busy, done;

    int checks   = 0;
    int errors   = 0;
    int edge_cnt = 0;
    int en_cnt   = 0;
    int done_cnt = 0;
    bit tmo      = 1'b0;

    logic [7:0] mdl_bytes [34];
    logic [7:0] got [9];
    bit         got_last [9];
    int         n_got;
    logic [7:0] stall_data [$];
    logic       done_end, busy_end;

    pe_array_ctrl_if #(.DW(8)) ld_if ();
    pe_array_ctrl_if #(.DW(8)) rs_if ();
    assign ld_if.last = 1'b0;

    pe_array_ctrl #(.RUN_CYCLES(RC), .DW(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start),
        .abort_i      (abort),
        .ld           (ld_if),
        .rs           (rs_if),
        .sum_in_i     (sum_in),
        .filter_flat_o(filter_flat),
        .ifmap_flat_o (ifmap_flat),
        .arr_rst_o    (arr_rst),
        .arr_en_o     (arr_en),
        .busy_o       (busy),
        .done_o       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        edge_cnt++;
        if (arr_en) en_cnt++;
        if (done) done_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic gen_bytes(input bit nominal);
        for (int i = 0; i < 34; i++)
            mdl_bytes[i] = nominal ? ((i < 9) ? 8'(i + 3) : 8'(i - 8)) : 8'($urandom);
    endtask

    // vmode: 0 valid held high, 1 valid every other cycle, 2 random valid
    task automatic feed(input int vmode);
        int idx = 0;
        int cyc = 0;
        bit ph  = 1'b1;
        bit hs;
        while (idx < 34) begin
            if (cyc >= 400) begin
                tmo = 1'b1;
                break;
            end
            case (vmode)
                0:       ld_if.valid = 1'b1;
                1:       begin ld_if.valid = ph; ph = ~ph; end
                default: ld_if.valid = 1'($urandom_range(0, 1));
            endcase
            ld_if.data = ld_if.valid ? mdl_bytes[idx] : 8'($urandom);
            hs = ld_if.valid && ld_if.ready;
            step();
            cyc++;
            if (hs) idx++;
        end
        ld_if.valid = 1'b0;
    endtask

    task automatic wait_drain();
        int cyc = 0;
        while (!rs_if.valid) begin
            if (cyc >= 100) begin
                tmo = 1'b1;
                break;
            end
            step();
            cyc++;
        end
    endtask

    // rmode: 0 ready held high, 1 three-cycle stall at byte 4, 2 random ready
    task automatic drain(input int rmode);
        int cyc   = 0;
        int stall = 0;
        n_got = 0;
        stall_data.delete();
        while (n_got < 9) begin
            if (cyc >= 300) begin
                tmo = 1'b1;
                break;
            end
            case (rmode)
                0: rs_if.ready = 1'b1;
                1: begin
                    if (n_got == 4 && stall < 3) begin
                        rs_if.ready = 1'b0;
                        stall++;
                        stall_data.push_back(rs_if.data);
                    end else begin
                        rs_if.ready = 1'b1;
                    end
                end
                default: rs_if.ready = 1'($urandom_range(0, 1));
            endcase
            if (rs_if.valid && rs_if.ready) begin
                got[n_got]      = rs_if.data;
                got_last[n_got] = rs_if.last;
                n_got++;
            end
            step();
            cyc++;
        end
        rs_if.ready = 1'b0;
        done_end = done;
        busy_end = busy;
    endtask

    task automatic start_job();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({ld_if.ready, rs_if.valid, rs_if.last, busy, done, arr_en, arr_rst} !== 7'b0000001) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000001", {ld_if.ready, rs_if.valid, rs_if.last, busy, done, arr_en, arr_rst});
        end
        checks++;
        if (rs_if.data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rs_if.data); end
        checks++;
        if (filter_flat !== 72'h0) begin errors++; $display("FAIL reset_filter: got %h expected 0", filter_flat); end
        checks++;
        if (ifmap_flat !== 200'h0) begin errors++; $display("FAIL reset_ifmap: got %h expected 0", ifmap_flat); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_nominal();
        int e0, bad;
        gen_bytes(1'b1);
        sum_in   = 72'h090807060504030201;
        tmo      = 1'b0;
        start_job();
        e0       = edge_cnt;
        en_cnt   = 0;
        done_cnt = 0;
        feed(0);
        wait_drain();
        checks++;
        if (edge_cnt - e0 !== 48) begin errors++; $display("FAIL nom_latency: got %0d edges expected 48", edge_cnt - e0); end
        checks++;
        if (en_cnt !== RC) begin errors++; $display("FAIL nom_run_cycles: got %0d expected %0d", en_cnt, RC); end
        checks++;
        if ({filter_flat[7:0], filter_flat[71:64], ifmap_flat[199:192]} !== 24'h030B19) begin
            errors++;
            $display("FAIL nom_corner_bytes: got %h expected 030b19", {filter_flat[7:0], filter_flat[71:64], ifmap_flat[199:192]});
        end
        bad = 0;
        for (int i = 0; i < 9; i++)  if (filter_flat[i*8 +: 8] !== mdl_bytes[i]) bad++;
        for (int i = 0; i < 25; i++) if (ifmap_flat[i*8 +: 8] !== mdl_bytes[9+i]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL nom_flat: %0d bytes wrong expected 0 (filter=%h)", bad, filter_flat); end
        checks++;
        if ({arr_rst, arr_en, busy, ld_if.ready} !== 4'b0010) begin
            errors++;
            $display("FAIL nom_drain_ctrl: got %b expected 0010", {arr_rst, arr_en, busy, ld_if.ready});
        end
        drain(0);
        bad = 0;
        for (int j = 0; j < 9; j++) if (got[j] !== 8'(j + 1) || got_last[j] !== (j == 8)) bad++;
        checks++;
        if (bad != 0 || n_got != 9) begin errors++; $display("FAIL nom_out_bytes: %0d wrong of %0d expected 0 of 9", bad, n_got); end
        checks++;
        if ({done_end, busy_end} !== 2'b10) begin errors++; $display("FAIL nom_done: got done/busy %b expected 10", {done_end, busy_end}); end
        step();
        checks++;
        if (done !== 1'b0 || done_cnt !== 1) begin errors++; $display("FAIL nom_done_pulse: got done=%b count=%0d expected 0 and 1", done, done_cnt); end
        checks++;
        if (tmo) begin errors++; $display("FAIL nom_timeout: got timeout expected none"); end
    endtask

    task automatic test_backpressure();
        int bad;
        gen_bytes(1'b0);
        sum_in = 72'h090807060504030201;
        tmo    = 1'b0;
        start_job();
        feed(1);
        wait_drain();
        bad = 0;
        for (int i = 0; i < 9; i++)  if (filter_flat[i*8 +: 8] !== mdl_bytes[i]) bad++;
        for (int i = 0; i < 25; i++) if (ifmap_flat[i*8 +: 8] !== mdl_bytes[9+i]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL bp_flat: %0d bytes wrong expected 0", bad); end
        drain(1);
        bad = 0;
        foreach (stall_data[i]) if (stall_data[i] !== 8'h05) bad++;
        checks++;
        if (bad != 0 || stall_data.size() != 3) begin
            errors++;
            $display("FAIL bp_stall_hold: %0d of %0d stalled bytes not 05 expected 0 of 3", bad, stall_data.size());
        end
        bad = 0;
        for (int j = 0; j < 9; j++) if (got[j] !== 8'(j + 1) || got_last[j] !== (j == 8)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL bp_out_bytes: %0d wrong expected 0", bad); end
        checks++;
        if (tmo || done_end !== 1'b1) begin errors++; $display("FAIL bp_done: got done=%b timeout=%b expected 1 0", done_end, tmo); end
    endtask

    task automatic test_ignored_start();
        int e0, bad;
        gen_bytes(1'b0);
        sum_in = {$urandom, $urandom, 8'($urandom)};
        tmo    = 1'b0;
        start  = 1'b1;
        step();
        e0 = edge_cnt;
        feed(0);
        wait_drain();
        checks++;
        if (edge_cnt - e0 !== 48) begin errors++; $display("FAIL ign_latency: got %0d edges expected 48", edge_cnt - e0); end
        bad = 0;
        for (int i = 0; i < 9; i++)  if (filter_flat[i*8 +: 8] !== mdl_bytes[i]) bad++;
        for (int i = 0; i < 25; i++) if (ifmap_flat[i*8 +: 8] !== mdl_bytes[9+i]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL ign_flat: %0d bytes wrong expected 0", bad); end
        drain(0);
        start = 1'b0;
        bad = 0;
        for (int j = 0; j < 9; j++) if (got[j] !== sum_in[j*8 +: 8] || got_last[j] !== (j == 8)) bad++;
        checks++;
        if (bad != 0 || done_end !== 1'b1) begin errors++; $display("FAIL ign_out: %0d wrong done=%b expected 0 and 1", bad, done_end); end
        step();
        checks++;
        if (busy !== 1'b0 || tmo) begin errors++; $display("FAIL ign_idle: got busy=%b timeout=%b expected 0 0", busy, tmo); end
    endtask

    task automatic test_abort();
        int bad, cyc;
        gen_bytes(1'b0);
        sum_in = {$urandom, $urandom, 8'($urandom)};
        tmo    = 1'b0;
        start_job();
        feed(0);
        cyc = 0;
        while (!arr_en && cyc < 10) begin step(); cyc++; end
        repeat (4) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if ({busy, arr_en, arr_rst, rs_if.valid} !== 4'b0010) begin
            errors++;
            $display("FAIL abort_run: got busy/en/rst/valid %b expected 0010", {busy, arr_en, arr_rst, rs_if.valid});
        end
        done_cnt = 0;
        repeat (20) step();
        checks++;
        if (done_cnt !== 0 || busy !== 1'b0) begin errors++; $display("FAIL abort_no_done: got %0d pulses busy=%b expected 0 0", done_cnt, busy); end
        // Second abort lands mid-LOAD so the restart must begin again at byte 0.
        start_job();
        ld_if.valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ld_if.data = 8'($urandom);
            step();
        end
        ld_if.valid = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        gen_bytes(1'b0);
        sum_in = {$urandom, $urandom, 8'($urandom)};
        start_job();
        feed(2);
        wait_drain();
        bad = 0;
        for (int i = 0; i < 9; i++)  if (filter_flat[i*8 +: 8] !== mdl_bytes[i]) bad++;
        for (int i = 0; i < 25; i++) if (ifmap_flat[i*8 +: 8] !== mdl_bytes[9+i]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL abort_restart_flat: %0d bytes wrong expected 0", bad); end
        drain(2);
        bad = 0;
        for (int j = 0; j < 9; j++) if (got[j] !== sum_in[j*8 +: 8] || got_last[j] !== (j == 8)) bad++;
        checks++;
        if (bad != 0 || done_end !== 1'b1 || tmo) begin
            errors++;
            $display("FAIL abort_restart_out: %0d wrong done=%b timeout=%b expected 0 1 0", bad, done_end, tmo);
        end
    endtask

    task automatic test_async_reset();
        int bad;
        gen_bytes(1'b0);
        sum_in = {$urandom, $urandom, 8'($urandom)};
        tmo    = 1'b0;
        start_job();
        feed(0);
        wait_drain();
        rs_if.ready = 1'b1;
        repeat (3) step();
        rs_if.ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rs_if.valid, busy, ld_if.ready, rs_if.last, done, arr_en, arr_rst} !== 7'b0000001 || rs_if.data !== 8'h00) begin
            errors++;
            $display("FAIL async_rst_ctrl: got %b data=%h expected 0000001 data=00",
                     {rs_if.valid, busy, ld_if.ready, rs_if.last, done, arr_en, arr_rst}, rs_if.data);
        end
        checks++;
        if (filter_flat !== 72'h0 || ifmap_flat !== 200'h0) begin
            errors++;
            $display("FAIL async_rst_flat: got filter=%h ifmap=%h expected zero", filter_flat, ifmap_flat);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        gen_bytes(1'b0);
        sum_in = {$urandom, $urandom, 8'($urandom)};
        start_job();
        feed(1);
        wait_drain();
        bad = 0;
        for (int i = 0; i < 9; i++)  if (filter_flat[i*8 +: 8] !== mdl_bytes[i]) bad++;
        for (int i = 0; i < 25; i++) if (ifmap_flat[i*8 +: 8] !== mdl_bytes[9+i]) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL async_restart_flat: %0d bytes wrong expected 0", bad); end
        drain(0);
        bad = 0;
        for (int j = 0; j < 9; j++) if (got[j] !== sum_in[j*8 +: 8]) bad++;
        checks++;
        if (bad != 0 || tmo) begin errors++; $display("FAIL async_restart_out: %0d wrong timeout=%b expected 0 0", bad, tmo); end
    endtask

    task automatic test_random_jobs();
        int bad;
        for (int n = 0; n < 3; n++) begin
            gen_bytes(1'b0);
            sum_in   = {$urandom, $urandom, 8'($urandom)};
            tmo      = 1'b0;
            en_cnt   = 0;
            start_job();
            feed(2);
            wait_drain();
            bad = 0;
            for (int i = 0; i < 9; i++)  if (filter_flat[i*8 +: 8] !== mdl_bytes[i]) bad++;
            for (int i = 0; i < 25; i++) if (ifmap_flat[i*8 +: 8] !== mdl_bytes[9+i]) bad++;
            checks++;
            if (bad != 0 || en_cnt !== RC) begin
                errors++;
                $display("FAIL rnd_load_run job%0d: %0d bytes wrong, %0d run cycles, expected 0 and %0d", n, bad, en_cnt, RC);
            end
            drain(2);
            bad = 0;
            for (int j = 0; j < 9; j++) if (got[j] !== sum_in[j*8 +: 8] || got_last[j] !== (j == 8)) bad++;
            checks++;
            if (bad != 0 || done_end !== 1'b1 || busy_end !== 1'b0 || tmo) begin
                errors++;
                $display("FAIL rnd_out job%0d: %0d wrong done=%b busy=%b timeout=%b expected 0 1 0 0", n, bad, done_end, busy_end, tmo);
            end
            repeat (2) step();
        end
    endtask

    initial begin
        ld_if.valid = 1'b0;
        ld_if.data  = '0;
        rs_if.ready = 1'b0;
        test_reset();
        test_nominal();
        test_backpressure();
        test_ignored_start();
        test_abort();
        test_async_reset();
        test_random_jobs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
